datapath_ctrl: RTL and testbench

Instruction sequencer sitting directly upstream of the 4×4-bit register file in the datapath. Accepts one 8-bit instruction at a time over a valid/ready handshake and drives the file's single shared port (addr, we, data_in) while consuming its registered read data. Executes load-immediate, move, add (with carry) and output instructions using a one-port, one-cycle-read-latency register file.

---
 rtl/datapath_ctrl_pkg.sv | 35 +++
 rtl/datapath_ctrl_alu.sv | 13 +
 rtl/datapath_ctrl.sv | 133 +++++++++++++
 tb/tb_datapath_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_ctrl_pkg.sv
// Shared definitions for the datapath instruction sequencer: opcodes, FSM states
// and the field layout of the latched instruction.
package datapath_ctrl_pkg;

  localparam int OPC_W = 2;

  typedef enum logic [OPC_W-1:0] {
    OP_LDI = 2'b00,
    OP_MOV = 2'b01,
    OP_ADD = 2'b10,
    OP_OUT = 2'b11
  } opcode_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_D = 3'd1,
    S_RD_S = 3'd2,
    S_EXE  = 3'd3,
    S_WR   = 3'd4
  } state_t;

  // The latched instruction keeps opcode, rd and rs only: {op, rd, rs}.
  function automatic int ir_width(input int aw);
    return OPC_W + 2 * aw;
  endfunction

  function automatic int ir_opc_lsb(input int aw);
    return 2 * aw;
  endfunction

  function automatic int ir_rd_lsb(input int aw);
    return aw;
  endfunction

endpackage

// File: rtl/datapath_ctrl_alu.sv
// Combinational DW-bit unsigned adder with carry out, used by the EXE state.
module alu_4bits #(
  parameter int DW = 4
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] sum,
  output logic          cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/datapath_ctrl.sv
// Instruction sequencer driving the single shared port of a one-cycle-latency
// register file: LDI, MOV, ADD (with carry) and OUT.
module datapath_ctrl
  import datapath_ctrl_pkg::*;
#(
  parameter int DW = 4,
  parameter int AW = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_valid,
  input  logic [2+AW+DW-1:0]  instr,
  output logic                instr_ready,
  output logic [AW-1:0]       rf_addr,
  output logic                rf_we,
  output logic [DW-1:0]       rf_wdata,
  input  logic [DW-1:0]       rf_rdata,
  output logic [DW-1:0]       result,
  output logic                result_valid,
  output logic                carry
);

  localparam int IW   = 2 + AW + DW;
  localparam int IRW  = ir_width(AW);
  localparam int OPCL = ir_opc_lsb(AW);
  localparam int RDL  = ir_rd_lsb(AW);

  state_t          state_q;
  logic [IRW-1:0]  ir_q;
  logic [DW-1:0]   wreg_q;
  logic [DW-1:0]   opa_q;
  logic            carry_q;
  logic [DW-1:0]   result_q;
  logic            result_valid_q;

  logic [DW-1:0]   alu_sum;
  logic            alu_cout;
  opcode_t         ir_op;
  opcode_t         in_op;
  logic [AW-1:0]   ir_rd;
  logic [AW-1:0]   ir_rs;

  assign ir_op = opcode_t'(ir_q[OPCL +: OPC_W]);
  assign ir_rd = ir_q[RDL +: AW];
  assign ir_rs = ir_q[0 +: AW];
  assign in_op = opcode_t'(instr[IW-1 -: OPC_W]);

  alu_4bits #(.DW(DW)) u_alu (
    .a    (opa_q),
    .b    (rf_rdata),
    .sum  (alu_sum),
    .cout (alu_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      ir_q           <= '0;
      wreg_q         <= '0;
      opa_q          <= '0;
      carry_q        <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (instr_valid) begin
            ir_q <= instr[IW-1 : DW-AW];
            case (in_op)
              OP_LDI: begin
                wreg_q  <= instr[DW-1:0];
                state_q <= S_WR;
              end
              OP_ADD:  state_q <= S_RD_D;
              default: state_q <= S_RD_S;
            endcase
          end
        end
        S_RD_D: state_q <= S_RD_S;
        S_RD_S: begin
          // rf_rdata now holds R[rd], requested during RD_D.
          if (ir_op == OP_ADD) begin
            opa_q <= rf_rdata;
          end
          state_q <= S_EXE;
        end
        S_EXE: begin
          case (ir_op)
            OP_ADD: begin
              wreg_q  <= alu_sum;
              carry_q <= alu_cout;
              state_q <= S_WR;
            end
            OP_MOV: begin
              wreg_q  <= rf_rdata;
              state_q <= S_WR;
            end
            default: begin
              result_q       <= rf_rdata;
              result_valid_q <= 1'b1;
              state_q        <= S_IDLE;
            end
          endcase
        end
        S_WR:    state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Port drive is combinational so a reset during WR suppresses the write at once.
  always_comb begin
    rf_addr = '0;
    rf_we   = 1'b0;
    case (state_q)
      S_RD_D:        rf_addr = ir_rd;
      S_RD_S, S_EXE: rf_addr = ir_rs;
      S_WR: begin
        rf_addr = ir_rd;
        rf_we   = 1'b1;
      end
      default: rf_addr = '0;
    endcase
  end

  assign rf_wdata     = wreg_q;
  assign instr_ready  = (state_q == S_IDLE);
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign carry        = carry_q;

endmodule

// File: tb/tb_datapath_ctrl.sv
// Bench for datapath_ctrl: behavioural register file, table-driven instruction
// vectors, OUT results checked through an expected-value queue.
module tb_datapath_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       instr_valid = 1'b0;
  logic [7:0] instr = '0;
  logic       instr_ready;
  logic [1:0] rf_addr;
  logic       rf_we;
  logic [3:0] rf_wdata;
  logic [3:0] rf_rdata = '0;
  logic [3:0] result;
  logic       result_valid;
  logic       carry;

  datapath_ctrl #(.DW(4), .AW(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_ready  (instr_ready),
    .rf_addr      (rf_addr),
    .rf_we        (rf_we),
    .rf_wdata     (rf_wdata),
    .rf_rdata     (rf_rdata),
    .result       (result),
    .result_valid (result_valid),
    .carry        (carry)
  );

  always #5 clk = ~clk;

  // Register file: one shared port, no reset, registered read when we=0.
  logic [3:0] mem [4];
  always @(posedge clk) begin
    if (rf_we) mem[rf_addr] <= rf_wdata;
    else       rf_rdata     <= mem[rf_addr];
  end

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int we_cnt = 0;
  int acc_q[$];
  logic [3:0] sb[$];
  logic prev_rv = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (instr_valid && instr_ready) acc_q.push_back(cyc);
      if (rf_we) we_cnt <= we_cnt + 1;
      if (result_valid) begin
        chk("rv_pulse_width", {31'd0, prev_rv}, 32'd0);
        if (sb.size() == 0) chk("sb_has_entry", sb.size(), 1);
        else begin
          $display("OUT result=%0h", result);
          chk("result", {28'd0, result}, {28'd0, sb.pop_front()});
        end
      end
    end
    prev_rv <= result_valid;
  end

  function automatic logic [7:0] enc(input logic [1:0] op, input int rd, input int lo);
    logic [1:0] r;
    logic [3:0] l;
    r = rd[1:0];
    l = lo[3:0];
    return {op, r, l};
  endfunction

  // lo field for register-source instructions: rs in [3:2].
  function automatic int rs(input int r);
    return r << 2;
  endfunction

  task automatic send(input logic [7:0] ins);
    int  n;
    logic acc;
    n = 0;
    acc = 1'b0;
    instr = ins;
    instr_valid = 1'b1;
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = instr_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("accept_timeout", {31'd0, acc}, 32'd1);
    $display("ACCEPT instr=%02h", ins);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!instr_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!instr_ready) chk("idle_timeout", {31'd0, instr_ready}, 32'd1);
  endtask

  typedef struct {
    logic [7:0] ins;
    bit         chk_c;
    logic       c;
    bit         is_out;
    logic [3:0] res;
  } vec_t;

  vec_t tbl[15];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{enc(2'b00, 0, 5),      0, 0, 0, 4'h0};
    tbl[1]  = '{enc(2'b00, 1, 3),      0, 0, 0, 4'h0};
    tbl[2]  = '{enc(2'b11, 0, rs(0)),  0, 0, 1, 4'h5};
    tbl[3]  = '{enc(2'b11, 0, rs(1)),  0, 0, 1, 4'h3};
    tbl[4]  = '{enc(2'b00, 2, 9),      0, 0, 0, 4'h0};
    tbl[5]  = '{enc(2'b00, 3, 8),      0, 0, 0, 4'h0};
    tbl[6]  = '{enc(2'b10, 2, rs(3)),  1, 1, 0, 4'h0};
    tbl[7]  = '{enc(2'b11, 0, rs(2)),  0, 0, 1, 4'h1};
    tbl[8]  = '{enc(2'b00, 0, 2),      0, 0, 0, 4'h0};
    tbl[9]  = '{enc(2'b10, 0, rs(0)),  1, 0, 0, 4'h0};
    tbl[10] = '{enc(2'b11, 0, rs(0)),  0, 0, 1, 4'h4};
    tbl[11] = '{enc(2'b00, 1, 10),     0, 0, 0, 4'h0};
    tbl[12] = '{enc(2'b01, 3, rs(1)),  0, 0, 0, 4'h0};
    tbl[13] = '{enc(2'b11, 0, rs(3)),  0, 0, 1, 4'hA};
    tbl[14] = '{enc(2'b11, 0, rs(1)),  0, 0, 1, 4'hA};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready",  {31'd0, instr_ready},  32'd1);
    chk("rst_we",     {31'd0, rf_we},        32'd0);
    chk("rst_addr",   {30'd0, rf_addr},      32'd0);
    chk("rst_result", {28'd0, result},       32'd0);
    chk("rst_rv",     {31'd0, result_valid}, 32'd0);
    chk("rst_carry",  {31'd0, carry},        32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Table-driven sequence, one instruction at a time
    for (int i = 0; i < 15; i++) begin
      if (tbl[i].is_out) sb.push_back(tbl[i].res);
      send(tbl[i].ins);
      instr_valid = 1'b0;
      wait_idle();
      if (tbl[i].chk_c) chk("carry", {31'd0, carry}, {31'd0, tbl[i].c});
    end
    repeat (3) @(posedge clk);
    #1;

    // Back-to-back stream with instr_valid held high
    acc_q.delete();
    we_cnt = 0;
    send(enc(2'b00, 2, 6));
    send(enc(2'b01, 3, rs(2)));
    send(enc(2'b10, 3, rs(2)));
    sb.push_back(4'hC);
    send(enc(2'b11, 0, rs(3)));
    instr_valid = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("stream_accepts", acc_q.size(), 4);
    chk("stream_we_cycles", we_cnt, 3);
    chk("stream_carry", {31'd0, carry}, 32'd0);
    if (acc_q.size() == 4) begin
      chk("gap_ldi", acc_q[1] - acc_q[0], 2);
      chk("gap_mov", acc_q[2] - acc_q[1], 4);
      chk("gap_add", acc_q[3] - acc_q[2], 5);
    end

    // Reset during WR of LDI R0,7 while R0 holds 4
    send(enc(2'b00, 0, 7));
    instr_valid = 1'b0;
    chk("we_in_wr", {31'd0, rf_we}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("we_drop_on_rst", {31'd0, rf_we},        32'd0);
    chk("rst2_ready",     {31'd0, instr_ready},  32'd1);
    chk("rst2_addr",      {30'd0, rf_addr},      32'd0);
    chk("rst2_result",    {28'd0, result},       32'd0);
    chk("rst2_rv",        {31'd0, result_valid}, 32'd0);
    chk("rst2_carry",     {31'd0, carry},        32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    sb.push_back(4'h4);
    send(enc(2'b11, 0, rs(0)));
    instr_valid = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk);
    #1;

    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
